// File: rtl/alu_pkg.sv
// Shared ALU encodings and operand-select constants for the issue stage and its users.
package alu_pkg;

   localparam int ALU_XLEN = 64;
   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;

   localparam logic SRC1_RS1 = 1'b0;
   localparam logic SRC1_PC  = 1'b1;
   localparam logic SRC2_RS2 = 1'b0;
   localparam logic SRC2_IMM = 1'b1;

endpackage

// File: rtl/alu_pipe_slice.sv
// Generic valid/ready register slice with synchronous flush; payload is opaque.
module alu_pipe_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         load;

   // flush wins over a same-cycle load; ready itself is left untouched
   always_comb begin
      in_ready = !valid_q || out_ready;
      load     = in_valid && in_ready && !flush;
      valid_d  = flush ? 1'b0 : (load || (valid_q && !out_ready));
      data_d   = load ? in_data : data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Two-slice IDU->ALU->WBU issue pipeline (fixed 2-cycle latency, full rate).
// Define ALU_ISSUE_PERF_EN to add the issue/stall performance counters.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = ALU_XLEN,
   parameter int OP_W = ALU_OP_W,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_src1_sel,
   input  logic            in_src2_sel,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   input  logic [OP_W-1:0] in_alu_op,
   input  logic            in_word,
   input  logic [RD_W-1:0] in_rd,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [OP_W-1:0] alu_op,
   input  logic [XLEN-1:0] alu_res,
`ifdef ALU_ISSUE_PERF_EN
   output logic [31:0]     perf_issue_cnt,
   output logic [31:0]     perf_stall_cnt,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [RD_W-1:0] out_rd
);

   localparam int A_W = 2 * XLEN + OP_W + 1 + RD_W;
   localparam int B_W = XLEN + RD_W;

   function automatic logic [XLEN-1:0] word_sext(input logic [XLEN-1:0] r);
      logic signed [31:0] lo;
      lo = r[31:0];
      return XLEN'(lo);
   endfunction

   logic [XLEN-1:0] sel_src1, sel_src2;
   logic [A_W-1:0]  a_in, a_data;
   logic [B_W-1:0]  b_in, b_data;
   logic            a_valid, b_valid, b_ready;
   logic [XLEN-1:0] a_src1, a_src2;
   logic [OP_W-1:0] a_op;
   logic            a_word;
   logic [RD_W-1:0] a_rd;

   // Slice A: operand select happens before the register
   always_comb begin
      sel_src1 = (in_src1_sel == SRC1_PC)  ? in_pc  : in_rs1;
      sel_src2 = (in_src2_sel == SRC2_IMM) ? in_imm : in_rs2;
      a_in     = {sel_src1, sel_src2, in_alu_op, in_word, in_rd};
   end

   alu_pipe_slice #(.W(A_W)) u_slice_a (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (a_in),
      .out_valid (a_valid),
      .out_ready (b_ready),
      .out_data  (a_data)
   );

   assign {a_src1, a_src2, a_op, a_word, a_rd} = a_data;
   assign alu_a  = a_src1;
   assign alu_b  = a_src2;
   assign alu_op = a_op;

   // Slice B: captures the combinational ALU result, W-ops sign-extended from bit 31
   assign b_in = {a_word ? word_sext(alu_res) : alu_res, a_rd};

   alu_pipe_slice #(.W(B_W)) u_slice_b (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (a_valid),
      .in_ready  (b_ready),
      .in_data   (b_in),
      .out_valid (b_valid),
      .out_ready (out_ready),
      .out_data  (b_data)
   );

   assign out_valid           = b_valid;
   assign {out_result, out_rd} = b_data;

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] issue_cnt_q, issue_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // counters ignore flush: a flushed accept still counts as issued
   always_comb begin
      issue_cnt_d = issue_cnt_q + {31'd0, (in_valid && in_ready)};
      stall_cnt_d = stall_cnt_q + {31'd0, (b_valid && !out_ready)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_issue_cnt = issue_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: external ALU model, scoreboard queue, vector table plus corner sequences.
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_src1_sel, in_src2_sel, in_word;
   logic [63:0] in_rs1, in_rs2, in_imm, in_pc, alu_a, alu_b, alu_res, out_result;
   logic [3:0]  in_alu_op, alu_op;
   logic [4:0]  in_rd, out_rd;
   logic        out_valid, out_ready;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
      .in_alu_op(in_alu_op), .in_word(in_word), .in_rd(in_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
`ifdef ALU_ISSUE_PERF_EN
      .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd)
   );

   always #5 clk = ~clk;

   // external combinational ALU
   always_comb begin
      case (alu_op)
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_SLL:  alu_res = alu_a << alu_b[5:0];
         ALU_SLT:  alu_res = {63'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_res = {63'd0, alu_a < alu_b};
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SRL:  alu_res = alu_a >> alu_b[5:0];
         ALU_SRA:  alu_res = $signed(alu_a) >>> alu_b[5:0];
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         default:  alu_res = 64'd0;
      endcase
   end

   typedef struct packed {
      logic        s1, s2;
      logic [63:0] rs1, rs2, imm, pc;
      logic [3:0]  op;
      logic        w;
      logic [4:0]  rd;
      logic [63:0] exp;
   } vec_t;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  rd;
      logic [31:0] cyc;
   } sb_t;

   sb_t         sb[$];
   int          tests = 0, fails = 0, n_out = 0;
   logic [31:0] cyc = 0, last_acc = 0;
   bit          lat_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard consumer: every WBU handshake must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_out++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got rd=%0d result %h expected no output", out_rd, out_result);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("out_result", out_result, e.res);
            check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
            if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
         end
      end
   end

   task automatic drive(input vec_t v);
      in_src1_sel = v.s1; in_src2_sel = v.s2;
      in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm; in_pc = v.pc;
      in_alu_op = v.op; in_word = v.w; in_rd = v.rd;
   endtask

   // offer one op starting #1 after a posedge; returns #1 after the accepting edge
   task automatic send(input vec_t v, input bit push);
      bit ok;
      ok = 1'b0;
      drive(v);
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            last_acc = cyc;
            if (push) sb.push_back({v.exp, v.rd, cyc});
            break;
         end
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   function automatic vec_t mk(input int r);
      vec_t v;
      v = '0;
      v.rs1 = 64'(r * 100); v.rs2 = 64'(r); v.op = ALU_ADD; v.rd = 5'(r);
      v.exp = 64'(r * 101);
      return v;
   endfunction

   vec_t        tbl[11];
   logic [31:0] first_acc;
   int          n0;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            s1 s2 rs1                    rs2                    imm     pc       op        w  rd  exp
      tbl[0]  = '{1'b0, 1'b0, 64'h10,               64'h5,                 64'h0,  64'h0,    ALU_ADD,  1'b0, 5'd3,  64'h15};
      tbl[1]  = '{1'b0, 1'b1, 64'h7fffffff,         64'h0,                 64'h1,  64'h0,    ALU_ADD,  1'b1, 5'd4,  64'hffffffff80000000};
      tbl[2]  = '{1'b0, 1'b0, 64'h5,                64'h7,                 64'h0,  64'h0,    ALU_SUB,  1'b0, 5'd5,  64'hfffffffffffffffe};
      tbl[3]  = '{1'b1, 1'b1, 64'h0,                64'h0,                 64'h20, 64'h1000, ALU_ADD,  1'b0, 5'd6,  64'h1020};
      tbl[4]  = '{1'b0, 1'b0, 64'hff00ff00,         64'h0ff00ff0,          64'h0,  64'h0,    ALU_AND,  1'b0, 5'd7,  64'h0f000f00};
      tbl[5]  = '{1'b0, 1'b0, 64'hf0,               64'hff,                64'h0,  64'h0,    ALU_XOR,  1'b0, 5'd8,  64'h0f};
      tbl[6]  = '{1'b0, 1'b0, 64'h1,                64'd63,                64'h0,  64'h0,    ALU_SLL,  1'b0, 5'd9,  64'h8000000000000000};
      tbl[7]  = '{1'b0, 1'b0, 64'h8000000000000000, 64'd4,                 64'h0,  64'h0,    ALU_SRA,  1'b0, 5'd10, 64'hf800000000000000};
      tbl[8]  = '{1'b0, 1'b0, 64'h0,                64'h1,                 64'h0,  64'h0,    ALU_SUB,  1'b1, 5'd11, 64'hffffffffffffffff};
      tbl[9]  = '{1'b0, 1'b0, 64'h100000005,        64'h3,                 64'h0,  64'h0,    ALU_ADD,  1'b1, 5'd12, 64'h8};
      tbl[10] = '{1'b0, 1'b0, 64'h1,                64'hffffffffffffffff,  64'h0,  64'h0,    ALU_SLTU, 1'b0, 5'd31, 64'h1};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive('0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_out_rd", {59'd0, out_rd}, 64'd0);
      check("rst_alu_a", alu_a, 64'd0);
      @(posedge clk); #1;

      // vector table, back to back at full rate
      lat_chk = 1'b1;
      send(tbl[0], 1'b1);
      first_acc = last_acc;
      for (int i = 1; i < 11; i++) send(tbl[i], 1'b1);
      check("throughput", 64'(last_acc - first_acc), 64'd10);
      repeat (4) @(negedge clk);
      lat_chk = 1'b0;
      check("table_drained", 64'(sb.size()), 64'd0);
      check("table_count", 64'(n_out), 64'd11);
      @(posedge clk); #1;

      // backpressure: rd 1..4 with WBU stalled, then released
      out_ready = 1'b0;
      n0 = n_out;
      fork
         begin
            for (int r = 1; r <= 4; r++) send(mk(r), 1'b1);
         end
         begin
            repeat (4) @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_rd_hold", {59'd0, out_rd}, 64'd1);
            check("bp_alu_a_hold", alu_a, 64'd200);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      repeat (5) @(negedge clk);
      check("bp_delivered", 64'(n_out - n0), 64'd4);
      check("bp_drained", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;

      // flush with two ops in flight and a third offered in the flush cycle
      n0 = n_out;
      drive(mk(10)); in_valid = 1'b1;
      sb.push_back({mk(10).exp, 5'd10, 32'd0});
      @(posedge clk); #1;
      drive(mk(11));
      @(posedge clk); #1;
      drive(mk(12)); flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      end
      check("flush_count", 64'(n_out - n0), 64'd1);
      @(posedge clk); #1;
      send(mk(13), 1'b1);
      repeat (3) @(negedge clk);
      check("post_flush_drained", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;

      // asynchronous reset in the middle of a stalled stream
      out_ready = 1'b0;
      send(mk(20), 1'b0);
      send(mk(21), 1'b0);
      @(negedge clk);
      check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_out_valid", {63'd0, out_valid}, 64'd0);
      check("async_out_result", out_result, 64'd0);
      check("async_out_rd", {59'd0, out_rd}, 64'd0);
      check("async_alu_a", alu_a, 64'd0);
      check("async_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;

`ifdef ALU_ISSUE_PERF_EN
      // counters: 5 accepts, exactly 3 stalled cycles
      for (int r = 1; r <= 4; r++) send(mk(r), 1'b1);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(mk(5), 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         @(negedge clk);
      end
      check("perf_out_valid", {63'd0, out_valid}, 64'd1);
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("perf_issue_cnt", {32'd0, perf_issue_cnt}, 64'd5);
      check("perf_stall_cnt", {32'd0, perf_stall_cnt}, 64'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
